// File: rtl/cache_arb_pkg.sv
// Shared types and helpers for the cache port arbiter.
//   state_t : arbiter FSM states (IDLE, BUSY, RESP)
//   owner_t : which CPU port owns the cache transaction (I or D)
//   op_t    : latched cache operation (read or write)
//   sat_inc : 32-bit saturating increment used by the statistics counters
package cache_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  localparam logic [31:0] CNT_MAX = '1;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == CNT_MAX) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/cache_port_arbiter_rr_arb2.sv
// Combinational two-requester picker for the cache port arbiter.
// Ports:
//   req_i, req_d : raw requests from the I and D ports
//   mask_i, mask_d : suppress a port (its valid is high this cycle)
//   last_owner   : port served by the previous transaction
//   gnt_valid    : at least one port is eligible
//   gnt_owner    : winning port (meaningful only when gnt_valid)
// FAIR=1 alternates on contention; FAIR=0 always prefers D.
module rr_arb2
  import cache_arb_pkg::*;
#(
  parameter int FAIR = 1
) (
  input  logic   req_i,
  input  logic   req_d,
  input  logic   mask_i,
  input  logic   mask_d,
  input  owner_t last_owner,
  output logic   gnt_valid,
  output owner_t gnt_owner
);

  logic elig_i;
  logic elig_d;

  always_comb begin
    elig_i    = req_i & ~mask_i;
    elig_d    = req_d & ~mask_d;
    gnt_valid = elig_i | elig_d;
    gnt_owner = OWNER_I;
    if (elig_i && elig_d) begin
      if (FAIR != 0) begin
        gnt_owner = (last_owner == OWNER_I) ? OWNER_D : OWNER_I;
      end else begin
        gnt_owner = OWNER_D;
      end
    end else if (elig_d) begin
      gnt_owner = OWNER_D;
    end
  end

endmodule

// File: rtl/cache_port_arbiter.sv
// Shares one unified cache between the instruction-fetch port (I, read only)
// and the data port (D, read/write). One transaction at a time:
// IDLE (arbitrate, latch request) -> BUSY (drive cache until c_miss drops)
// -> RESP (capture read data, pulse owner's valid on the following cycle).
// Ports:
//   clk, rst                : clock, synchronous active-low reset
//   i_req/i_addr            : instruction read request
//   i_rdata/i_valid/i_stall : instruction response, one-cycle valid pulse
//   d_rd_req/d_wr_req/d_addr/d_wdata : data request (both high = write)
//   d_rdata/d_valid/d_stall : data response, one-cycle valid pulse
//   c_addr/c_rd_req/c_wr_req/c_wr_data : request to the cache
//   c_rd_data/c_miss        : cache response / busy indication
//   txn_cnt, miss_cyc_cnt   : saturating statistics
module cache_port_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int FAIR   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_valid,
  output logic              i_stall,
  input  logic              d_rd_req,
  input  logic              d_wr_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              d_stall,
  output logic [ADDR_W-1:0] c_addr,
  output logic              c_rd_req,
  output logic              c_wr_req,
  output logic [DATA_W-1:0] c_wr_data,
  input  logic [DATA_W-1:0] c_rd_data,
  input  logic              c_miss,
  output logic [31:0]       txn_cnt,
  output logic [31:0]       miss_cyc_cnt
);

  state_t state;
  state_t state_nxt;
  owner_t owner;
  owner_t last_owner;
  op_t    op;
  logic   d_any;
  logic   gnt_valid;
  owner_t gnt_owner;

  assign d_any   = d_rd_req | d_wr_req;
  assign i_stall = i_req & ~i_valid;
  assign d_stall = d_any & ~d_valid;

  // A port whose valid is high is masked so a requester that has just been
  // served cannot be re-granted on its stale request.
  rr_arb2 #(
    .FAIR(FAIR)
  ) u_arb (
    .req_i     (i_req),
    .req_d     (d_any),
    .mask_i    (i_valid),
    .mask_d    (d_valid),
    .last_owner(last_owner),
    .gnt_valid (gnt_valid),
    .gnt_owner (gnt_owner)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    c_rd_req  = 1'b0;
    c_wr_req  = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_valid) state_nxt = BUSY;
      end
      BUSY: begin
        c_rd_req = (op == OP_RD);
        c_wr_req = (op == OP_WR);
        if (!c_miss) state_nxt = RESP;
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      owner        <= OWNER_I;
      last_owner   <= OWNER_D;
      op           <= OP_RD;
      c_addr       <= '0;
      c_wr_data    <= '0;
      i_rdata      <= '0;
      d_rdata      <= '0;
      i_valid      <= 1'b0;
      d_valid      <= 1'b0;
      txn_cnt      <= '0;
      miss_cyc_cnt <= '0;
    end else begin
      i_valid <= 1'b0;
      d_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            owner <= gnt_owner;
            if (gnt_owner == OWNER_I) begin
              c_addr <= i_addr;
              op     <= OP_RD;
            end else begin
              c_addr    <= d_addr;
              c_wr_data <= d_wdata;
              op        <= d_wr_req ? OP_WR : OP_RD;
            end
          end
        end
        BUSY: begin
          if (c_miss) miss_cyc_cnt <= sat_inc(miss_cyc_cnt);
        end
        RESP: begin
          if (owner == OWNER_I) begin
            i_valid <= 1'b1;
            if (op == OP_RD) i_rdata <= c_rd_data;
          end else begin
            d_valid <= 1'b1;
            if (op == OP_RD) d_rdata <= c_rd_data;
          end
          last_owner <= owner;
          txn_cnt    <= sat_inc(txn_cnt);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Scoreboard bench for cache_port_arbiter: stimulus pushes expected responses,
// a forked monitor pops and compares them whenever a valid pulse appears.
// dut0 uses FAIR=1 with a cache model supporting misses and writes;
// dut1 uses FAIR=0 with an always-hit read-only cache model.
module tb_cache_port_arbiter;

  typedef struct {
    bit          is_d;
    logic [31:0] data;
    int          exp_cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t q0[$];
  exp_t q1[$];

  // dut0 signals
  logic        i_req, d_rd_req, d_wr_req;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [31:0] i_rdata, d_rdata, c_addr, c_wr_data, c_rd_data, txn_cnt, miss_cyc_cnt;
  logic        i_valid, i_stall, d_valid, d_stall, c_rd_req, c_wr_req, c_miss;

  // dut1 signals
  logic        f0_i_req, f0_d_rd_req, f0_d_wr_req;
  logic [31:0] f0_i_addr, f0_d_addr, f0_d_wdata;
  logic [31:0] f0_i_rdata, f0_d_rdata, f0_c_addr, f0_c_wr_data, f0_c_rd_data;
  logic [31:0] f0_txn_cnt, f0_miss_cyc_cnt;
  logic        f0_i_valid, f0_i_stall, f0_d_valid, f0_d_stall;
  logic        f0_c_rd_req, f0_c_wr_req, f0_c_miss;

  cache_port_arbiter #(.ADDR_W(32), .DATA_W(32), .FAIR(1)) u_dut0 (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid), .i_stall(i_stall),
    .d_rd_req(d_rd_req), .d_wr_req(d_wr_req), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
    .c_addr(c_addr), .c_rd_req(c_rd_req), .c_wr_req(c_wr_req), .c_wr_data(c_wr_data),
    .c_rd_data(c_rd_data), .c_miss(c_miss),
    .txn_cnt(txn_cnt), .miss_cyc_cnt(miss_cyc_cnt)
  );

  cache_port_arbiter #(.ADDR_W(32), .DATA_W(32), .FAIR(0)) u_dut1 (
    .clk(clk), .rst(rst),
    .i_req(f0_i_req), .i_addr(f0_i_addr), .i_rdata(f0_i_rdata), .i_valid(f0_i_valid),
    .i_stall(f0_i_stall),
    .d_rd_req(f0_d_rd_req), .d_wr_req(f0_d_wr_req), .d_addr(f0_d_addr), .d_wdata(f0_d_wdata),
    .d_rdata(f0_d_rdata), .d_valid(f0_d_valid), .d_stall(f0_d_stall),
    .c_addr(f0_c_addr), .c_rd_req(f0_c_rd_req), .c_wr_req(f0_c_wr_req),
    .c_wr_data(f0_c_wr_data), .c_rd_data(f0_c_rd_data), .c_miss(f0_c_miss),
    .txn_cnt(f0_txn_cnt), .miss_cyc_cnt(f0_miss_cyc_cnt)
  );

  // Unwritten locations return a fixed pattern; 0x40 holds 0xDEADBEEF.
  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a == 32'h40) ? 32'hDEADBEEF : (a ^ 32'hC0DE0000);
  endfunction

  // dut0 cache model: miss_budget BUSY cycles of c_miss before each commit.
  int           miss_budget;
  int           miss_cnt = 0;
  logic [255:0] written = '0;
  logic [31:0]  mem [256];

  assign c_miss = (c_rd_req || c_wr_req) && (miss_cnt < miss_budget);

  always @(posedge clk) begin
    if (!rst) begin
      miss_cnt <= 0;
    end else if (c_rd_req || c_wr_req) begin
      if (c_miss) begin
        miss_cnt <= miss_cnt + 1;
      end else begin
        miss_cnt <= 0;
        if (c_wr_req) begin
          mem[c_addr[9:2]]     <= c_wr_data;
          written[c_addr[9:2]] <= 1'b1;
        end else begin
          c_rd_data <= written[c_addr[9:2]] ? mem[c_addr[9:2]] : dflt(c_addr);
        end
      end
    end
  end

  // dut1 cache model: always hits, reads only.
  assign f0_c_miss = 1'b0;
  always @(posedge clk) begin
    if (f0_c_rd_req) f0_c_rd_data <= dflt(f0_c_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (i_valid || d_valid) begin
        if (q0.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL dut0_unexpected_valid: i_valid=%0b d_valid=%0b with no pending expectation",
                   i_valid, d_valid);
        end else begin
          e = q0.pop_front();
          chk("dut0_port_is_d", {31'b0, d_valid}, {31'b0, e.is_d});
          chk("dut0_rdata", d_valid ? d_rdata : i_rdata, e.data);
          if (e.exp_cyc >= 0) chk("dut0_latency_cycle", cyc, e.exp_cyc);
        end
      end
      if (f0_i_valid || f0_d_valid) begin
        if (q1.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL dut1_unexpected_valid: i_valid=%0b d_valid=%0b with no pending expectation",
                   f0_i_valid, f0_d_valid);
        end else begin
          e = q1.pop_front();
          chk("dut1_port_is_d", {31'b0, f0_d_valid}, {31'b0, e.is_d});
          chk("dut1_rdata", f0_d_valid ? f0_d_rdata : f0_i_rdata, e.data);
        end
      end
    end
  endtask

  // which: 0 = dut0 I, 1 = dut0 D
  task automatic wait_valid(input int which, input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      seen = (which == 0) ? i_valid : d_valid;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s: no valid within 60 cycles, expected one", name);
    end
  endtask

  initial begin
    int ni;
    int nd;
    int issue;

    rst = 1'b0;
    i_req = 1'b1; i_addr = 32'h40;
    d_rd_req = 1'b0; d_wr_req = 1'b0; d_addr = '0; d_wdata = '0;
    f0_i_req = 1'b0; f0_i_addr = '0;
    f0_d_rd_req = 1'b0; f0_d_wr_req = 1'b0; f0_d_addr = '0; f0_d_wdata = '0;
    miss_budget = 0;

    fork
      monitor();
    join_none

    // Reset held three edges with I requesting.
    repeat (3) @(negedge clk);
    chk("rst_i_valid", {31'b0, i_valid}, 32'd0);
    chk("rst_d_valid", {31'b0, d_valid}, 32'd0);
    chk("rst_c_rd_req", {31'b0, c_rd_req}, 32'd0);
    chk("rst_c_wr_req", {31'b0, c_wr_req}, 32'd0);
    chk("rst_txn_cnt", txn_cnt, 32'd0);
    chk("rst_miss_cyc_cnt", miss_cyc_cnt, 32'd0);
    chk("rst_i_rdata", i_rdata, 32'd0);

    // Release: I read hit at 0x40.
    rst = 1'b1;
    issue = cyc;
    q0.push_back('{1'b0, 32'hDEADBEEF, issue + 3});
    @(negedge clk);
    chk("i_hit_granted_rd_req", {31'b0, c_rd_req}, 32'd1);
    chk("i_hit_c_addr", c_addr, 32'h40);
    chk("i_hit_i_stall", {31'b0, i_stall}, 32'd1);
    wait_valid(0, "i_hit_wait");
    i_req = 1'b0;
    chk("i_hit_txn_cnt", txn_cnt, 32'd1);

    // D write 0x1234 to 0x80 with 5 miss cycles; write leaves d_rdata at 0.
    @(negedge clk);
    miss_budget = 5;
    d_wr_req = 1'b1; d_addr = 32'h80; d_wdata = 32'h1234;
    issue = cyc;
    q0.push_back('{1'b1, 32'h0, issue + 8});
    @(negedge clk);
    chk("d_wr_c_wr_req", {31'b0, c_wr_req}, 32'd1);
    chk("d_wr_c_wr_data", c_wr_data, 32'h1234);
    chk("d_wr_d_stall", {31'b0, d_stall}, 32'd1);
    chk("d_wr_i_stall", {31'b0, i_stall}, 32'd0);
    wait_valid(1, "d_wr_wait");
    d_wr_req = 1'b0;
    chk("d_wr_miss_cyc_cnt", miss_cyc_cnt, 32'd5);
    chk("d_wr_txn_cnt", txn_cnt, 32'd2);

    // D read back 0x80.
    @(negedge clk);
    miss_budget = 0;
    d_rd_req = 1'b1; d_addr = 32'h80;
    issue = cyc;
    q0.push_back('{1'b1, 32'h1234, issue + 3});
    wait_valid(1, "d_rd_wait");
    d_rd_req = 1'b0;

    // Read and write both high is a write.
    @(negedge clk);
    d_rd_req = 1'b1; d_wr_req = 1'b1; d_addr = 32'h84; d_wdata = 32'h55;
    q0.push_back('{1'b1, 32'h1234, -1});
    @(negedge clk);
    chk("rdwr_is_write_wr", {31'b0, c_wr_req}, 32'd1);
    chk("rdwr_is_write_rd", {31'b0, c_rd_req}, 32'd0);
    wait_valid(1, "rdwr_wait");
    d_rd_req = 1'b0; d_wr_req = 1'b0;
    @(negedge clk);
    d_rd_req = 1'b1; d_addr = 32'h84;
    issue = cyc;
    q0.push_back('{1'b1, 32'h55, issue + 3});
    wait_valid(1, "rd84_wait");
    d_rd_req = 1'b0;
    chk("pre_fair_miss_cyc_cnt", miss_cyc_cnt, 32'd5);
    chk("pre_fair_txn_cnt", txn_cnt, 32'd5);

    // FAIR=1 contention, last owner is D: I, D, I, D.
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h100;
    d_rd_req = 1'b1; d_addr = 32'h200;
    q0.push_back('{1'b0, 32'hC0DE0100, -1});
    q0.push_back('{1'b1, 32'hC0DE0200, -1});
    q0.push_back('{1'b0, 32'hC0DE0100, -1});
    q0.push_back('{1'b1, 32'hC0DE0200, -1});
    @(negedge clk);
    chk("fair1_i_stall", {31'b0, i_stall}, 32'd1);
    chk("fair1_d_stall", {31'b0, d_stall}, 32'd1);
    chk("fair1_first_grant_addr", c_addr, 32'h100);
    ni = 0; nd = 0;
    for (int k = 0; k < 60 && !(ni == 2 && nd == 2); k++) begin
      @(negedge clk);
      if (i_valid) begin
        ni++;
        chk("fair1_d_pending_stall", {31'b0, d_stall}, 32'd1);
        chk("fair1_i_stall_on_valid", {31'b0, i_stall}, 32'd0);
        if (ni == 2) i_req = 1'b0;
      end
      if (d_valid) begin
        nd++;
        if (nd == 2) d_rd_req = 1'b0;
      end
    end
    chk("fair1_txn_total", ni + nd, 32'd4);
    chk("fair1_txn_cnt", txn_cnt, 32'd9);

    // FAIR=0 contention on dut1: D, I, D, I.
    @(negedge clk);
    f0_i_req = 1'b1; f0_i_addr = 32'h100;
    f0_d_rd_req = 1'b1; f0_d_addr = 32'h200;
    q1.push_back('{1'b1, 32'hC0DE0200, -1});
    q1.push_back('{1'b0, 32'hC0DE0100, -1});
    q1.push_back('{1'b1, 32'hC0DE0200, -1});
    q1.push_back('{1'b0, 32'hC0DE0100, -1});
    @(negedge clk);
    chk("fair0_first_grant_addr", f0_c_addr, 32'h200);
    chk("fair0_i_stall", {31'b0, f0_i_stall}, 32'd1);
    ni = 0; nd = 0;
    for (int k = 0; k < 60 && !(ni == 2 && nd == 2); k++) begin
      @(negedge clk);
      if (f0_i_valid) begin
        ni++;
        if (ni == 2) f0_i_req = 1'b0;
      end
      if (f0_d_valid) begin
        nd++;
        chk("fair0_i_pending_stall", {31'b0, f0_i_stall}, 32'd1);
        if (nd == 2) f0_d_rd_req = 1'b0;
      end
    end
    chk("fair0_txn_total", ni + nd, 32'd4);
    chk("fair0_txn_cnt", f0_txn_cnt, 32'd4);

    // Reset while BUSY with c_miss high: transaction abandoned, no valid.
    @(negedge clk);
    miss_budget = 10;
    i_req = 1'b1; i_addr = 32'h300;
    repeat (3) @(negedge clk);
    chk("midrst_busy_rd_req", {31'b0, c_rd_req}, 32'd1);
    chk("midrst_busy_c_miss", {31'b0, c_miss}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    i_req = 1'b0;
    miss_budget = 0;
    chk("midrst_c_rd_req", {31'b0, c_rd_req}, 32'd0);
    chk("midrst_i_valid", {31'b0, i_valid}, 32'd0);
    chk("midrst_txn_cnt", txn_cnt, 32'd0);
    chk("midrst_miss_cyc_cnt", miss_cyc_cnt, 32'd0);
    repeat (5) @(negedge clk);
    chk("midrst_idle_rd_req", {31'b0, c_rd_req}, 32'd0);
    chk("midrst_idle_wr_req", {31'b0, c_wr_req}, 32'd0);
    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_port_arbiter.md
Name: cache_port_arbiter

Overview:
- Shares the single unified cache between the CPU instruction-fetch port (I, read-only) and the data port (D, read/write).
- Grants one port at a time and presents that port's request to the cache. Holds the request until the cache drops its miss signal.
- Returns the read data and a one-cycle valid pulse to the owning port.
- Keeps transaction and miss-cycle statistics.

Parameters:
- ADDR_W, 32, width of the address on all ports.
- DATA_W, 32, width of data words on all ports.
- FAIR, 1. 1 selects round-robin between I and D. 0 selects fixed priority, with D ahead of I.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- i_req  in  1  instruction read request, held until i_valid
- i_addr  in  ADDR_W  instruction address, stable while i_req is high
- i_rdata  out  DATA_W  instruction read data, registered, holds its last value
- i_valid  out  1  one-cycle completion pulse for I
- i_stall  out  1  i_req & ~i_valid
- d_rd_req  in  1  data read request
- d_wr_req  in  1  data write request
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  data write value
- d_rdata  out  DATA_W  data read data, registered, holds its last value
- d_valid  out  1  one-cycle completion pulse for D
- d_stall  out  1  (d_rd_req | d_wr_req) & ~d_valid
- c_addr  out  ADDR_W  cache request address
- c_rd_req  out  1  cache read request
- c_wr_req  out  1  cache write request
- c_wr_data  out  DATA_W  cache write data
- c_rd_data  in  DATA_W  cache read data; valid on the cycle after the edge where c_miss==0
- c_miss  in  1  cache miss/busy, combinational from the cache request
- txn_cnt  out  32  completed transactions, saturating
- miss_cyc_cnt  out  32  BUSY cycles with c_miss=1, saturating

Behaviour:
- Reset (rst=0 at a clk edge):
  - state goes to IDLE; last_owner=D.
  - All valids, c_rd_req, c_wr_req, rdata registers, c_addr, c_wr_data and both counters are 0.
  - A mid-transaction reset abandons the transaction with no valid pulse.
  - At top level the cache reset is driven from ~rst, so both blocks reset together.
- State machine: IDLE, BUSY, RESP.
- IDLE:
  - Cache requests are held low.
  - Eligible ports: I if i_req & ~i_valid; D if (d_rd_req | d_wr_req) & ~d_valid. A port whose valid is high this cycle is masked.
  - If exactly one port is eligible, it wins.
  - If both are eligible: with FAIR=1 the winner is the port that is not last_owner; with FAIR=0, D wins.
  - On the winning edge, latch owner, addr, wdata and op, then go to BUSY.
  - d_rd_req and d_wr_req both high is treated as a write.
- BUSY:
  - Drive c_addr and c_wr_data from the latched values; raise c_rd_req or c_wr_req per op.
  - If c_miss=1, stay in BUSY and increment miss_cyc_cnt.
  - If c_miss=0, the cache commits at this edge; go to RESP.
- RESP:
  - Cache requests are low.
  - On the exit edge, on a read load the owner's rdata register from c_rd_data. A write leaves rdata unchanged.
  - Pulse the owner's valid for the next cycle, set last_owner=owner, increment txn_cnt, go to IDLE.
- Latency for a cache hit: request seen at edge E, owner valid high in the cycle after edge E+2. Minimum spacing is 3 cycles per transaction.
- Counters: saturate at 0xFFFF_FFFF and do not wrap.
- Requester contract: inputs are held stable from the request until valid is seen. The requester may drop the request or change to a new one on the cycle after valid.
- The non-owner's request stays pending with its stall asserted until it is granted.

Decomposition:
- Package cache_arb_pkg:
  - state enum {IDLE, BUSY, RESP};
  - owner typedef (OWNER_I=0, OWNER_D=1);
  - op typedef (OP_RD, OP_WR).
- Sub-module rr_arb2: combinational two-request picker with FAIR, last_owner and masks as inputs, grant as output. This lets it be tested alone.

Test Plan:
- Reset: hold rst=0 for 3 cycles with i_req=1 -> valids, cache requests and both counters are 0. Release -> I is granted on the next edge.
- I read hit: i_addr=0x40, cache returns 0xDEADBEEF with c_miss=0 -> i_valid is a single pulse 3 cycles after the request, i_rdata=0xDEADBEEF, txn_cnt=1.
- D write then read with a 5-cycle miss:
  - write 0x1234 to 0x80 with c_miss high for 5 BUSY cycles -> miss_cyc_cnt=5 and one d_valid.
  - then read 0x80 -> d_rdata=0x1234.
- Simultaneous requests, FAIR=1: i_req and d_rd_req held high for 4 transactions -> grant order I, D, I, D, and the stalls track correctly.
- Simultaneous requests, FAIR=0: same stimulus -> D is granted every time it is eligible. I is served only in the IDLE cycle where d_valid masks D.
- Reset mid-BUSY: assert rst=0 while c_miss=1 -> no valid pulse, c_rd_req=0 the next cycle, state IDLE.
